// File: rtl/axi_mem_responder_pkg.sv
// Shared types and default geometry for the AXI memory responder.
// The module derives its own widths from its parameters; these are the defaults.
package axi_mem_responder_pkg;

    localparam int LP_BYTES = 16;
    localparam int LP_LSB   = $clog2(LP_BYTES);
    localparam int LP_IDX_W = 10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rstate_t;

endpackage

// File: rtl/axi_mem_responder_ram.sv
// Single-clock RAM: byte-enabled write port, read-first synchronous read port.
module axi_mem_responder_ram #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                ap_clk,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge ap_clk) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (we && be[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Separate nonblocking read returns the pre-write word on a same-cycle collision.
    always_ff @(posedge ap_clk) begin
        if (re) begin
            dout <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: independent single-burst write and read engines over a
// byte-enabled RAM, with a 2-entry read output buffer so stalls never cost a bubble.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 64,
    parameter int C_DATA_WIDTH = 8 * LP_BYTES,
    parameter int C_MEM_DEPTH  = 1 << LP_IDX_W
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                      s_axi_rlast,
    output logic                      wlast_err,
    output logic [31:0]               wr_beats,
    output logic [31:0]               rd_beats
);

    localparam int BYTES = C_DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(C_MEM_DEPTH);

    wstate_t           wstate, wstate_nxt;
    logic [IDX_W-1:0]  widx;
    logic [7:0]        wlen, wcnt;
    logic              wbeat, w_final, aw_hs;

    rstate_t           rstate, rstate_nxt;
    logic [IDX_W-1:0]  ridx, raddr_ram;
    logic [7:0]        rlen;
    logic [8:0]        issued;
    logic              ar_hs, pop, issue, issue_last, out_free, skid_load;
    logic [1:0]        occ_after;
    logic              vld_p1, last_p1;
    logic [C_DATA_WIDTH-1:0] dout_p1;
    logic              skid_vld, skid_last;
    logic [C_DATA_WIDTH-1:0] skid_data;

    // Byte-offset bits and aliased upper bits do not select a word.
    logic addr_unused;
    assign addr_unused = ^{s_axi_awaddr[C_ADDR_WIDTH-1:LSB+IDX_W], s_axi_awaddr[LSB-1:0],
                           s_axi_araddr[C_ADDR_WIDTH-1:LSB+IDX_W], s_axi_araddr[LSB-1:0]};

    assign aw_hs   = s_axi_awvalid & s_axi_awready;
    assign wbeat   = s_axi_wvalid & s_axi_wready;
    assign w_final = (wcnt == wlen);

    always_comb begin
        wstate_nxt    = wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wstate)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_final) wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wstate    <= W_IDLE;
            wlast_err <= 1'b0;
            wr_beats  <= '0;
        end else begin
            wstate <= wstate_nxt;
            if (wbeat) begin
                wr_beats <= wr_beats + 32'd1;
                if (s_axi_wlast != w_final) wlast_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (aw_hs) begin
            widx <= s_axi_awaddr[LSB +: IDX_W];
            wlen <= s_axi_awlen;
            wcnt <= 8'd0;
        end else if (wbeat) begin
            widx <= widx + IDX_W'(1);
            wcnt <= wcnt + 8'd1;
        end
    end

    // Read issue: a beat is fetched only if it will have a buffer slot when it lands.
    assign ar_hs     = s_axi_arvalid & s_axi_arready;
    assign pop       = s_axi_rvalid & s_axi_rready;
    assign out_free  = ~s_axi_rvalid | s_axi_rready;
    assign skid_load = vld_p1 & (skid_vld | ~out_free);
    assign occ_after = 2'(s_axi_rvalid) + 2'(skid_vld) + 2'(vld_p1) - 2'(pop);

    always_comb begin
        rstate_nxt    = rstate;
        s_axi_arready = 1'b0;
        issue         = 1'b0;
        issue_last    = 1'b0;
        raddr_ram     = ridx;
        case (rstate)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                raddr_ram     = s_axi_araddr[LSB +: IDX_W];
                if (s_axi_arvalid) begin
                    rstate_nxt = R_BURST;
                    issue      = 1'b1;
                    issue_last = (s_axi_arlen == 8'd0);
                end
            end
            R_BURST: begin
                issue      = (issued <= {1'b0, rlen}) && (occ_after < 2'd2);
                issue_last = (issued == {1'b0, rlen});
                if (pop && s_axi_rlast) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            rstate       <= R_IDLE;
            issued       <= '0;
            vld_p1       <= 1'b0;
            skid_vld     <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            s_axi_rdata  <= '0;
            rd_beats     <= '0;
        end else begin
            rstate <= rstate_nxt;
            vld_p1 <= issue;
            if (ar_hs) issued <= 9'd1;
            else if (issue) issued <= issued + 9'd1;
            if (pop) rd_beats <= rd_beats + 32'd1;
            if (out_free) begin
                if (skid_vld) begin
                    s_axi_rvalid <= 1'b1;
                    s_axi_rdata  <= skid_data;
                    s_axi_rlast  <= skid_last;
                end else begin
                    s_axi_rvalid <= vld_p1;
                    if (vld_p1) begin
                        s_axi_rdata <= dout_p1;
                        s_axi_rlast <= last_p1;
                    end
                end
            end
            skid_vld <= skid_load | (skid_vld & ~out_free);
        end
    end

    // ---- RAM output stage (p1) into skid buffer ----
    always_ff @(posedge ap_clk) begin
        last_p1 <= issue_last;
        if (skid_load) begin
            skid_data <= dout_p1;
            skid_last <= last_p1;
        end
        if (ar_hs) begin
            ridx <= s_axi_araddr[LSB +: IDX_W] + IDX_W'(1);
            rlen <= s_axi_arlen;
        end else if (issue) begin
            ridx <= ridx + IDX_W'(1);
        end
    end

    axi_mem_responder_ram #(
        .DATA_W (C_DATA_WIDTH),
        .DEPTH  (C_MEM_DEPTH),
        .ADDR_W (IDX_W)
    ) u_ram (
        .ap_clk (ap_clk),
        .we     (wbeat & ~areset),
        .be     (s_axi_wstrb),
        .waddr  (widx),
        .wdata  (s_axi_wdata),
        .re     (issue & ~areset),
        .raddr  (raddr_ram),
        .dout   (dout_p1)
    );

endmodule
